// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the CPU port (A)
// and the debug/DMA loader port (B); one registered transaction at a time.
//   state  | meaning
//   IDLE   | sample requests, grant one, latch its command
//   ACCESS | single RAM select cycle; writes complete here
//   RDWAIT | wait out RAM read latency, capture data, ack
module data_mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              resIn,
    input  logic              reqA,
    input  logic              weA,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [DATA_W-1:0] wdataA,
    output logic [DATA_W-1:0] rdataA,
    output logic              ackA,
    input  logic              reqB,
    input  logic              weB,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] wdataB,
    output logic [DATA_W-1:0] rdataB,
    output logic              ackB,
    output logic              busy,
    output logic              memSel,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2
    } stateT;

    stateT             state, stateNext;
    logic [LAT_W-1:0]  lat, latNext;
    logic              rrPtr;
    logic              curPort;
    logic              curWe;
    logic [ADDR_W-1:0] curAddr;
    logic [DATA_W-1:0] curWdata;
    logic [DATA_W-1:0] rdataRegA, rdataRegB;
    logic              grantValid, grantPort, capture;

    // Port id 0 = A, 1 = B; on a tie rrPtr decides.
    assign grantValid = reqA | reqB;
    assign grantPort  = (reqA && reqB) ? rrPtr : reqB;

    always_ff @(posedge clk or posedge resIn) begin
        if (resIn) begin
            state     <= IDLE;
            lat       <= '0;
            rrPtr     <= 1'b0;
            curPort   <= 1'b0;
            curWe     <= 1'b0;
            curAddr   <= '0;
            curWdata  <= '0;
            rdataRegA <= '0;
            rdataRegB <= '0;
        end else begin
            state <= stateNext;
            lat   <= latNext;
            if (state == IDLE && grantValid) begin
                curPort  <= grantPort;
                curWe    <= grantPort ? weB : weA;
                curAddr  <= grantPort ? addrB : addrA;
                curWdata <= grantPort ? wdataB : wdataA;
                rrPtr    <= ~grantPort;
            end
            if (capture) begin
                if (curPort) rdataRegB <= memRdata;
                else         rdataRegA <= memRdata;
            end
        end
    end

    always_comb begin
        stateNext = state;
        latNext   = lat;
        memSel    = 1'b0;
        memWe     = 1'b0;
        memAddr   = '0;
        memWdata  = '0;
        ackA      = 1'b0;
        ackB      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (grantValid) stateNext = ACCESS;
            end
            ACCESS: begin
                memSel   = 1'b1;
                memWe    = curWe;
                memAddr  = curAddr;
                memWdata = curWdata;
                if (curWe) begin
                    ackA      = ~curPort;
                    ackB      = curPort;
                    stateNext = IDLE;
                end else begin
                    latNext   = LAT_INIT;
                    stateNext = RDWAIT;
                end
            end
            RDWAIT: begin
                if (lat != '0) begin
                    latNext = lat - LAT_W'(1);
                end else begin
                    capture   = 1'b1;
                    ackA      = ~curPort;
                    ackB      = curPort;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Read data is bypassed in the ack cycle so it is valid alongside ack.
    assign rdataA = (capture && !curPort) ? memRdata : rdataRegA;
    assign rdataB = (capture &&  curPort) ? memRdata : rdataRegB;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: stimulus pushes expected RAM-bus cycles
// and acks into queues, a negedge monitor pops and compares.
module tb_data_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              resIn;
    logic              reqA, weA, reqB, weB;
    logic [ADDR_W-1:0] addrA, addrB;
    logic [DATA_W-1:0] wdataA, wdataB;
    logic [DATA_W-1:0] rdataA, rdataB;
    logic              ackA, ackB, busy, memSel, memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata;
    logic [DATA_W-1:0] memRdata;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .resIn(resIn),
        .reqA(reqA), .weA(weA), .addrA(addrA), .wdataA(wdataA), .rdataA(rdataA), .ackA(ackA),
        .reqB(reqB), .weB(weB), .addrB(addrB), .wdataB(wdataB), .rdataB(rdataB), .ackB(ackB),
        .busy(busy), .memSel(memSel), .memWe(memWe), .memAddr(memAddr),
        .memWdata(memWdata), .memRdata(memRdata)
    );

    always #5 clk = ~clk;

    // RAM model with one cycle of read latency.
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (memSel) begin
            if (memWe) ram[memAddr] <= memWdata;
            memRdata <= ram[memAddr];
        end
    end

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } memExpT;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] rdata;
    } ackExpT;

    memExpT memQ[$];
    ackExpT ackQA[$];
    ackExpT ackQB[$];
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] holdA = '0;
    logic [DATA_W-1:0] holdB = '0;
    memExpT memE;
    ackExpT ackE;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic pushMem(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        memQ.push_back('{we: we, addr: addr, wdata: wdata});
    endtask

    // Monitor
    always @(negedge clk) begin
        if (resIn) begin
            holdA = '0;
            holdB = '0;
        end else begin
            if (memSel) begin
                if (memQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL memUnexpected actual addr=%0h required=none", memAddr);
                end else begin
                    memE = memQ.pop_front();
                    check("memBus", 64'({memWe, memAddr, memWdata}), 64'({memE.we, memE.addr, memE.wdata}));
                end
            end else begin
                check("memIdleZero", 64'({memWe, memAddr, memWdata}), 64'd0);
            end
            check("ackExclusive", 64'(ackA & ackB), 64'd0);
            if (ackA) begin
                if (ackQA.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ackAUnexpected actual=1 required=0");
                end else begin
                    ackE = ackQA.pop_front();
                    if (ackE.we) check("ackAWriteCycle", 64'({memSel, memWe}), 64'd3);
                    else begin
                        check("rdataA", 64'(rdataA), 64'(ackE.rdata));
                        holdA = ackE.rdata;
                    end
                    check("rdataBHold", 64'(rdataB), 64'(holdB));
                end
            end
            if (ackB) begin
                if (ackQB.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ackBUnexpected actual=1 required=0");
                end else begin
                    ackE = ackQB.pop_front();
                    if (ackE.we) check("ackBWriteCycle", 64'({memSel, memWe}), 64'd3);
                    else begin
                        check("rdataB", 64'(rdataB), 64'(ackE.rdata));
                        holdB = ackE.rdata;
                    end
                    check("rdataAHold", 64'(rdataA), 64'(holdA));
                end
            end
        end
    end

    // Request issued right after a posedge; ack latency counted in negedges.
    task automatic txnA(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                        input logic [DATA_W-1:0] expRd, input bit chkLat);
        int n;
        bit got;
        ackQA.push_back('{we: we, rdata: expRd});
        @(posedge clk); #2;
        reqA = 1'b1; weA = we; addrA = addr; wdataA = wdata;
        n = 0; got = 0;
        while (!got && n < 50) begin
            @(negedge clk); n++;
            if (ackA) got = 1;
        end
        reqA = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ackATimeout actual=none required=ack");
        end else if (chkLat) begin
            check("latencyA", 64'(n), we ? 64'd2 : 64'(2 + RD_LAT));
        end
    endtask

    task automatic txnB(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                        input logic [DATA_W-1:0] expRd, input bit chkLat);
        int n;
        bit got;
        ackQB.push_back('{we: we, rdata: expRd});
        @(posedge clk); #2;
        reqB = 1'b1; weB = we; addrB = addr; wdataB = wdata;
        n = 0; got = 0;
        while (!got && n < 50) begin
            @(negedge clk); n++;
            if (ackB) got = 1;
        end
        reqB = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL ackBTimeout actual=none required=ack");
        end else if (chkLat) begin
            check("latencyB", 64'(n), we ? 64'd2 : 64'(2 + RD_LAT));
        end
    endtask

    task automatic checkAllZero(input string name);
        check({name, "Rdata"}, 64'({rdataA, rdataB}), 64'd0);
        check({name, "Ctrl"}, 64'({ackA, ackB, busy, memSel, memWe, memAddr, memWdata}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
        for (int i = 0; i < 4; i++) ram[12'h200 + i] = 16'hB000 + 16'(i);
        ram[12'hFFF] = 16'h1234;
        ram[12'h055] = 16'hCAFE;
        memRdata = '0;
        resIn = 1'b1;
        reqA = 0; weA = 0; addrA = '0; wdataA = '0;
        reqB = 0; weB = 0; addrB = '0; wdataB = '0;
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #2 resIn = 1'b0;

        // Both ports contending from reset: A,B,A,B,...
        for (int i = 0; i < 4; i++) begin
            pushMem(1'b1, 12'h100 + 12'(i), 16'hA000 + 16'(i));
            pushMem(1'b0, 12'h200 + 12'(i), 16'h0000);
        end
        fork
            for (int i = 0; i < 4; i++) txnA(1'b1, 12'h100 + 12'(i), 16'hA000 + 16'(i), 16'h0, 1'b0);
            for (int j = 0; j < 4; j++) txnB(1'b0, 12'h200 + 12'(j), 16'h0, 16'hB000 + 16'(j), 1'b0);
        join
        check("contendWrite", 64'(ram[12'h103]), 64'h0000A003);

        // Write then read back through port A
        pushMem(1'b1, 12'h010, 16'hBEEF);
        txnA(1'b1, 12'h010, 16'hBEEF, 16'h0, 1'b1);
        pushMem(1'b0, 12'h010, 16'h0000);
        txnA(1'b0, 12'h010, 16'h0, 16'hBEEF, 1'b1);

        // Port B read at top address; rdataA must hold
        pushMem(1'b0, 12'hFFF, 16'h0000);
        txnB(1'b0, 12'hFFF, 16'h0, 16'h1234, 1'b1);

        // Port B drops req one cycle after grant
        pushMem(1'b0, 12'h055, 16'h0000);
        ackQB.push_back('{we: 1'b0, rdata: 16'hCAFE});
        @(posedge clk); #2;
        reqB = 1'b1; weB = 1'b0; addrB = 12'h055; wdataB = 16'h0;
        @(posedge clk);
        @(posedge clk); #2;
        reqB = 1'b0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (ackB) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL dropReqAck actual=none required=ack");
        end
        repeat (5) @(negedge clk);
        check("dropReqIdle", 64'(busy), 64'd0);

        // Reset in the middle of a read
        pushMem(1'b0, 12'h010, 16'h0000);
        @(posedge clk); #2;
        reqA = 1'b1; weA = 1'b0; addrA = 12'h010; wdataA = 16'h0;
        @(posedge clk);
        @(negedge clk);
        #2;
        resIn = 1'b1;
        reqA = 1'b0;
        #1;
        checkAllZero("midReset");
        repeat (2) @(posedge clk);
        #2 resIn = 1'b0;
        repeat (3) @(negedge clk);
        pushMem(1'b0, 12'h010, 16'h0000);
        txnA(1'b0, 12'h010, 16'h0, 16'hBEEF, 1'b1);

        repeat (4) @(negedge clk);
        check("memQEmpty", 64'(memQ.size()), 64'd0);
        check("ackQAEmpty", 64'(ackQA.size()), 64'd0);
        check("ackQBEmpty", 64'(ackQB.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
